// File: rtl/aux_uart_tx.sv
// ---------------------------------------------------------------------------
// aux_uart_tx : FIFO-buffered 8N1 UART transmitter (8E1 with AUX_UART_TX_PARITY_EN)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aux_uart_tx #(
   parameter int CLK_FREQUENCY = 50000000,
   parameter int BAUD_RATE     = 115200,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_valid,
   input  logic [7:0]                    wr_data,
   output logic                          wr_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int C_DIV = (CLK_FREQUENCY + BAUD_RATE / 2) / BAUD_RATE;
   localparam int C_CW  = (C_DIV > 2) ? $clog2(C_DIV) : 1;
   localparam int C_AW  = $clog2(FIFO_DEPTH);
   localparam logic [C_CW-1:0] C_LAST = C_CW'(C_DIV - 1);
   localparam logic [C_AW:0]   C_FULL = (C_AW + 1)'(FIFO_DEPTH);

   generate
      if (C_DIV < 2) begin : g_div_check
         $error("aux_uart_tx: clk cycles per bit must be at least 2");
      end
      if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
         $error("aux_uart_tx: FIFO_DEPTH must be a power of two, minimum 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [C_CW-1:0]   cnt_q, cnt_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              ovf_q;
   logic [C_AW:0]     wptr_q, rptr_q;
   logic [7:0]        mem_q [FIFO_DEPTH];

   logic [C_AW:0]     count;
   logic              empty, full, push, pop, bit_end;
   logic [7:0]        head;

   assign count      = wptr_q - rptr_q;
   assign empty      = (count == '0);
   assign full       = (count == C_FULL);
   assign push       = wr_valid && !full;
   assign head       = mem_q[rptr_q[C_AW-1:0]];
   assign bit_end    = (cnt_q == C_LAST);

   assign wr_ready   = !full;
   assign fifo_count = count;
   assign overflow   = ovf_q;
   assign tx         = tx_q;
   assign busy       = (state_q != S_IDLE) || !empty;

`ifdef AUX_UART_TX_PARITY_EN
   logic par_q, par_d;
   localparam state_t C_AFTER_DATA = S_PARITY;
`else
   localparam state_t C_AFTER_DATA = S_STOP;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
`ifdef AUX_UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d   = '0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = C_AFTER_DATA;
               end
            end
         end
`ifdef AUX_UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               // Chain straight into the next start bit when more data is queued.
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
`ifdef AUX_UART_TX_PARITY_EN
      if (pop) begin
         par_d = ^head;
      end
`endif
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
`ifdef AUX_UART_TX_PARITY_EN
         S_PARITY: tx_d = par_d;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         tx_q    <= 1'b1;
         ovf_q   <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
`ifdef AUX_UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         if (wr_valid && full) begin
            ovf_q <= 1'b1;
         end
         if (push) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_q <= rptr_q + 1'b1;
         end
`ifdef AUX_UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // Storage is not reset; cleared pointers make old contents unreachable.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q[C_AW-1:0]] <= wr_data;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_aux_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_aux_uart_tx : directed self-checking bench for aux_uart_tx (DIV = 10)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_aux_uart_tx;

   localparam int DIV   = 10;
`ifdef AUX_UART_TX_PARITY_EN
   localparam int NSLOT = 11;
`else
   localparam int NSLOT = 10;
`endif
   localparam int FL    = NSLOT * DIV;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       tx;
   logic       busy;
   logic [3:0] fifo_count;
   logic       overflow;

   int n_tests = 0;
   int n_fail  = 0;

   aux_uart_tx #(
      .CLK_FREQUENCY (1000000),
      .BAUD_RATE     (100000),
      .FIFO_DEPTH    (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Checks tx every cycle of one frame starting at bit offset i0; optionally
   // pushes a byte on the edge that ends the stop bit.
   task automatic expect_frame(input logic [7:0] b, input int i0, input bit do_push,
                               input logic [7:0] pb, input string tag);
      logic e;
      int   slot;
      for (int i = i0; i < FL; i++) begin
         slot = i / DIV;
         if (slot == 0)             e = 1'b0;
         else if (slot <= 8)        e = b[slot-1];
         else if (slot == NSLOT-1)  e = 1'b1;
         else                       e = ^b;
         chk(tag, {31'd0, tx}, {31'd0, e});
         if (i == FL - 1) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            if (do_push) begin
               wr_valid = 1'b1;
               wr_data  = pb;
            end
         end
         step();
      end
      wr_valid = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      wr_valid = 1'b0;
      wr_data  = 8'h00;
      step();
      step();
      chk("rst_tx",       {31'd0, tx},       32'd1);
      chk("rst_busy",     {31'd0, busy},     32'd0);
      chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
      chk("rst_count",    {28'd0, fifo_count}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      reset = 1'b0;
      step();

      // Single byte
      wr_valid = 1'b1; wr_data = 8'h55;
      step();
      wr_valid = 1'b0;
      chk("single_idle_tx", {31'd0, tx},   32'd1);
      chk("single_busy",    {31'd0, busy}, 32'd1);
      chk("single_count",   {28'd0, fifo_count}, 32'd1);
      step();
      chk("single_popped",  {28'd0, fifo_count}, 32'd0);
      expect_frame(8'h55, 0, 1'b0, 8'h00, "single_0x55");
      chk("single_busy_end", {31'd0, busy}, 32'd0);
      chk("single_tx_end",   {31'd0, tx},   32'd1);
      repeat (3) step();

      // Back-to-back
      wr_valid = 1'b1; wr_data = 8'hA3;
      step();
      wr_data = 8'h0F;
      step();
      wr_valid = 1'b0;
      expect_frame(8'hA3, 0, 1'b0, 8'h00, "b2b_0xA3");
      expect_frame(8'h0F, 0, 1'b0, 8'h00, "b2b_0x0F");
      chk("b2b_busy_end", {31'd0, busy}, 32'd0);
      repeat (3) step();

      // Full / overflow
      for (int k = 0; k < 10; k++) begin
         wr_valid = 1'b1;
         wr_data  = k[7:0];
         step();
         if (k == 1) chk("ovf_count_k1", {28'd0, fifo_count}, 32'd1);
         if (k == 8) begin
            chk("ovf_wr_ready_full", {31'd0, wr_ready}, 32'd0);
            chk("ovf_count_full",    {28'd0, fifo_count}, 32'd8);
            chk("ovf_not_yet",       {31'd0, overflow}, 32'd0);
         end
      end
      wr_valid = 1'b0;
      chk("ovf_set",        {31'd0, overflow}, 32'd1);
      chk("ovf_count_drop", {28'd0, fifo_count}, 32'd8);
      expect_frame(8'h00, 8, 1'b0, 8'h00, "ovf_byte0");
      for (int k = 1; k < 9; k++) begin
         expect_frame(k[7:0], 0, 1'b0, 8'h00, "ovf_byte");
      end
      chk("ovf_idle_tx",  {31'd0, tx},       32'd1);
      chk("ovf_busy_end", {31'd0, busy},     32'd0);
      chk("ovf_sticky",   {31'd0, overflow}, 32'd1);
      repeat (3) step();

      // Reset mid-frame, during data bit 3 of 0xFF with another byte queued
      wr_valid = 1'b1; wr_data = 8'hFF;
      step();
      wr_data = 8'h22;
      step();
      wr_valid = 1'b0;
      repeat (45) step();
      chk("midrst_busy_before", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      step();
      chk("midrst_tx",       {31'd0, tx},       32'd1);
      chk("midrst_busy",     {31'd0, busy},     32'd0);
      chk("midrst_count",    {28'd0, fifo_count}, 32'd0);
      chk("midrst_overflow", {31'd0, overflow}, 32'd0);
      reset = 1'b0;
      step();
      chk("midrst_still_idle", {31'd0, busy}, 32'd0);
      wr_valid = 1'b1; wr_data = 8'h01;
      step();
      wr_valid = 1'b0;
      step();
      expect_frame(8'h01, 0, 1'b0, 8'h00, "midrst_0x01");
      chk("midrst_busy_end", {31'd0, busy}, 32'd0);
      repeat (3) step();

      // Simultaneous push/pop at the end of a stop bit
      for (int k = 0; k < 4; k++) begin
         wr_valid = 1'b1;
         wr_data  = 8'h11 * (k + 1);
         step();
      end
      wr_valid = 1'b0;
      chk("pp_count_before", {28'd0, fifo_count}, 32'd3);
      expect_frame(8'h11, 2, 1'b1, 8'h55, "pp_0x11");
      chk("pp_count_after", {28'd0, fifo_count}, 32'd3);
      expect_frame(8'h22, 0, 1'b0, 8'h00, "pp_0x22");
      expect_frame(8'h33, 0, 1'b0, 8'h00, "pp_0x33");
      expect_frame(8'h44, 0, 1'b0, 8'h00, "pp_0x44");
      expect_frame(8'h55, 0, 1'b0, 8'h00, "pp_0x55");
      chk("pp_busy_end", {31'd0, busy}, 32'd0);
      repeat (3) step();

`ifdef AUX_UART_TX_PARITY_EN
      // Parity: 0x07 carries parity 1, 0x03 carries parity 0
      wr_valid = 1'b1; wr_data = 8'h07;
      step();
      wr_valid = 1'b0;
      step();
      repeat (90) step();
      chk("par_0x07_bit", {31'd0, tx}, 32'd1);
      repeat (10) step();
      chk("par_0x07_stop", {31'd0, tx}, 32'd1);
      repeat (9) step();
      chk("par_0x07_busy_last", {31'd0, busy}, 32'd1);
      step();
      chk("par_0x07_len", {31'd0, busy}, 32'd0);
      wr_valid = 1'b1; wr_data = 8'h03;
      step();
      wr_valid = 1'b0;
      step();
      expect_frame(8'h03, 0, 1'b0, 8'h00, "par_0x03");
      chk("par_0x03_busy_end", {31'd0, busy}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
